// File: rtl/idma_pkg.sv
// Shared iDMA definitions: AXI response codes, worst-response helper and the
// write-response merge FSM state type.
package idma_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Write-response merge states: idle / holding the first half of a split burst
   typedef enum logic {
      B_IDLE,
      B_WAIT2
   } b_state_t;

   // Severity follows the numeric encoding OKAY < EXOKAY < SLVERR < DECERR
   function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/axi_split_flag_fifo.sv
// Small in-order FIFO holding one split flag per issued logical burst.
// A push against a full FIFO is taken only if a pop happens in the same cycle;
// a pop against an empty FIFO is ignored. The full flag is registered and
// therefore lags the count by one cycle.
module axi_split_flag_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 1,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full,
   output logic [AW:0]      count
);

   localparam logic [AW:0] LP_CNT_FULL = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             r_full;

   logic             w_do_pop;
   logic             w_do_push;

   assign w_do_pop  = pop & (r_count != '0);
   assign w_do_push = push & ((r_count != LP_CNT_FULL) | w_do_pop);

   // Storage, pointers (wrap naturally at DEPTH), occupancy and registered full
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         r_full <= (r_count == LP_CNT_FULL);
      end
   end

   assign dout  = r_mem[r_rd_ptr];
   assign empty = (r_count == '0);
   assign full  = r_full;
   assign count = r_count;

endmodule

// File: rtl/axi_resp_merge4k.sv
// Rejoins R beats and B responses of logical DMA bursts that the address side
// split at a 4 KiB boundary into two AXI transactions. The intermediate RLAST
// is hidden and the two BRESPs are merged into the worst of the pair. Both
// paths are combinational pass-through gated by a per-direction split-flag FIFO.
module axi_resp_merge4k
   import idma_pkg::*;
#(
   parameter int unsigned AXI_IDW = 4,
   parameter int unsigned DATAW   = 256,
   parameter int unsigned DEPTH   = 4
) (
   input  logic               aclk,
   input  logic               areset,

   input  logic               ar_split_push,
   input  logic               ar_split_flag,
   output logic               ar_split_full,
   input  logic               aw_split_push,
   input  logic               aw_split_flag,
   output logic               aw_split_full,

   input  logic               i_rvalid,
   input  logic               i_rlast,
   input  logic [AXI_IDW-1:0] i_rid,
   input  logic [DATAW-1:0]   i_rdata,
   input  logic [1:0]         i_rresp,
   output logic               o_rready,

   output logic               dma_rvalid,
   output logic               dma_rlast,
   output logic [AXI_IDW-1:0] dma_rid,
   output logic [DATAW-1:0]   dma_rdata,
   output logic [1:0]         dma_rresp,
   input  logic               dma_rready,

   input  logic               i_bvalid,
   input  logic [AXI_IDW-1:0] i_bid,
   input  logic [1:0]         i_bresp,
   output logic               o_bready,

   output logic               dma_bvalid,
   output logic [AXI_IDW-1:0] dma_bid,
   output logic [1:0]         dma_bresp,
   input  logic               dma_bready
);

   localparam int unsigned AW = $clog2(DEPTH);

   // ---------------------------------------------------------------- flag FIFOs
   logic          w_rhead;
   logic          w_rempty;
   logic [AW:0]   w_rcount;
   logic          w_rpop;

   logic          w_bhead;
   logic          w_bempty;
   logic [AW:0]   w_bcount;
   logic          w_bpop;

   logic          w_unused;

   axi_split_flag_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (1)
   ) u_rflag_fifo (
      .clk   (aclk),
      .rst   (areset),
      .push  (ar_split_push),
      .din   (ar_split_flag),
      .pop   (w_rpop),
      .dout  (w_rhead),
      .empty (w_rempty),
      .full  (ar_split_full),
      .count (w_rcount)
   );

   axi_split_flag_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (1)
   ) u_bflag_fifo (
      .clk   (aclk),
      .rst   (areset),
      .push  (aw_split_push),
      .din   (aw_split_flag),
      .pop   (w_bpop),
      .dout  (w_bhead),
      .empty (w_bempty),
      .full  (aw_split_full),
      .count (w_bcount)
   );

   assign w_unused = ^{w_rcount, w_bcount};

   // ----------------------------------------------------------------- read path
   logic r_seg2;
   logic w_r_first;
   logic w_r_hs;

   // First segment of a split burst: its RLAST must not reach the DMA side
   assign w_r_first  = ~w_rempty & w_rhead & ~r_seg2;

   assign dma_rvalid = i_rvalid & ~w_rempty;
   assign o_rready   = dma_rready & ~w_rempty;
   assign dma_rdata  = i_rdata;
   assign dma_rid    = i_rid;
   assign dma_rresp  = i_rresp;
   assign dma_rlast  = i_rlast & ~w_r_first;

   assign w_r_hs     = i_rvalid & o_rready;
   assign w_rpop     = w_r_hs & i_rlast & ~w_r_first;

   // Track whether the second segment of a split read is in flight
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_seg2 <= 1'b0;
      end else if (w_r_hs & i_rlast) begin
         // set at the hidden RLAST, cleared at the real one
         r_seg2 <= w_r_first;
      end
   end

   // ---------------------------------------------------------------- write path
   b_state_t   r_bstate;
   logic [1:0] r_bhold;
   logic       w_b_absorb;

   // Response steering: absorb first half of a split, merge or pass the rest
   always_comb begin
      dma_bvalid = 1'b0;
      o_bready   = 1'b0;
      dma_bresp  = i_bresp;
      w_bpop     = 1'b0;
      w_b_absorb = 1'b0;
      if (!w_bempty) begin
         case (r_bstate)
            B_IDLE: begin
               if (w_bhead) begin
                  o_bready   = 1'b1;
                  w_b_absorb = i_bvalid;
               end else begin
                  dma_bvalid = i_bvalid;
                  o_bready   = dma_bready;
                  w_bpop     = i_bvalid & dma_bready;
               end
            end
            B_WAIT2: begin
               dma_bvalid = i_bvalid;
               o_bready   = dma_bready;
               dma_bresp  = resp_worst(r_bhold, i_bresp);
               w_bpop     = i_bvalid & dma_bready;
            end
            default: begin
               dma_bvalid = 1'b0;
               o_bready   = 1'b0;
            end
         endcase
      end
   end

   assign dma_bid = i_bid;

   // Merge FSM state and held first-half response
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_bstate <= B_IDLE;
         r_bhold  <= RESP_OKAY;
      end else begin
         case (r_bstate)
            B_IDLE: begin
               if (w_b_absorb) begin
                  r_bhold  <= i_bresp;
                  r_bstate <= B_WAIT2;
               end
            end
            B_WAIT2: begin
               if (w_bpop) begin
                  r_bstate <= B_IDLE;
               end
            end
            default: r_bstate <= B_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_resp_merge4k.sv
// Scoreboard bench for axi_resp_merge4k: drivers push the expected DMA-side
// beats/responses of each logical burst, monitors pop and compare on handshake.
module tb_axi_resp_merge4k;

   localparam int IDW   = 4;
   localparam int DW    = 256;
   localparam int DEPTH = 4;
   localparam int NB    = 40;

   logic           aclk;
   logic           areset;
   logic           ar_split_push, ar_split_flag, ar_split_full;
   logic           aw_split_push, aw_split_flag, aw_split_full;
   logic           i_rvalid, i_rlast;
   logic [IDW-1:0] i_rid;
   logic [DW-1:0]  i_rdata;
   logic [1:0]     i_rresp;
   logic           o_rready;
   logic           dma_rvalid, dma_rlast;
   logic [IDW-1:0] dma_rid;
   logic [DW-1:0]  dma_rdata;
   logic [1:0]     dma_rresp;
   logic           dma_rready;
   logic           i_bvalid;
   logic [IDW-1:0] i_bid;
   logic [1:0]     i_bresp;
   logic           o_bready;
   logic           dma_bvalid;
   logic [IDW-1:0] dma_bid;
   logic [1:0]     dma_bresp;
   logic           dma_bready;

   typedef struct {
      logic [DW-1:0]  data;
      logic [IDW-1:0] id;
      logic [1:0]     resp;
      logic           last;
   } rexp_t;

   typedef struct {
      logic [IDW-1:0] id;
      logic [1:0]     resp;
   } bexp_t;

   rexp_t rq[$];
   bexp_t bq[$];
   rexp_t re;
   bexp_t be;

   int checks   = 0;
   int failures = 0;
   int r_pushed = 0, r_done = 0, w_pushed = 0, w_done = 0;
   int rdy_mode = 0;

   bit rflag[NB];
   int rl1[NB], rl2[NB];
   bit wflag[NB];
   logic [1:0] wr1[NB], wr2[NB];

   axi_resp_merge4k #(
      .AXI_IDW (IDW),
      .DATAW   (DW),
      .DEPTH   (DEPTH)
   ) dut (
      .aclk          (aclk),
      .areset        (areset),
      .ar_split_push (ar_split_push),
      .ar_split_flag (ar_split_flag),
      .ar_split_full (ar_split_full),
      .aw_split_push (aw_split_push),
      .aw_split_flag (aw_split_flag),
      .aw_split_full (aw_split_full),
      .i_rvalid      (i_rvalid),
      .i_rlast       (i_rlast),
      .i_rid         (i_rid),
      .i_rdata       (i_rdata),
      .i_rresp       (i_rresp),
      .o_rready      (o_rready),
      .dma_rvalid    (dma_rvalid),
      .dma_rlast     (dma_rlast),
      .dma_rid       (dma_rid),
      .dma_rdata     (dma_rdata),
      .dma_rresp     (dma_rresp),
      .dma_rready    (dma_rready),
      .i_bvalid      (i_bvalid),
      .i_bid         (i_bid),
      .i_bresp       (i_bresp),
      .o_bready      (o_bready),
      .dma_bvalid    (dma_bvalid),
      .dma_bid       (dma_bid),
      .dma_bresp     (dma_bresp),
      .dma_bready    (dma_bready)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Worst response by numeric rank OKAY < EXOKAY < SLVERR < DECERR
   function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
      return (a >= b) ? a : b;
   endfunction

   // Consumer-side ready generator: 0 always ready, 1 toggle, 2 random
   initial begin
      dma_rready = 1'b0;
      dma_bready = 1'b0;
      forever begin
         @(posedge aclk); #1;
         case (rdy_mode)
            0: begin dma_rready = 1'b1; dma_bready = 1'b1; end
            1: begin dma_rready = ~dma_rready; dma_bready = ~dma_bready; end
            default: begin
               dma_rready = ($urandom_range(0, 2) != 0);
               dma_bready = ($urandom_range(0, 2) != 0);
            end
         endcase
      end
   end

   // R monitor
   always @(negedge aclk) begin
      if (dma_rvalid) chk("r_ready_mirror", o_rready, dma_rready);
      if (dma_rvalid && dma_rready) begin
         if (rq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL r_extra actual=beat required=none at %0t", $time);
         end else begin
            re = rq.pop_front();
            checks++;
            if (dma_rdata !== re.data) begin
               failures++;
               $display("FAIL r_data actual=%h required=%h", dma_rdata, re.data);
            end
            chk("r_id", dma_rid, re.id);
            chk("r_resp", dma_rresp, re.resp);
            chk("r_last", dma_rlast, re.last);
         end
      end
   end

   // B monitor
   always @(negedge aclk) begin
      if (dma_bvalid) chk("b_ready_mirror", o_bready, dma_bready);
      if (dma_bvalid && dma_bready) begin
         if (bq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL b_extra actual=resp%0d required=none at %0t", dma_bresp, $time);
         end else begin
            be = bq.pop_front();
            chk("b_id", dma_bid, be.id);
            chk("b_resp", dma_bresp, be.resp);
         end
      end
   end

   task automatic do_reset();
      areset = 1'b1;
      ar_split_push = 1'b0; aw_split_push = 1'b0;
      i_rvalid = 1'b0; i_bvalid = 1'b0; i_rlast = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
      areset = 1'b0;
      r_pushed = 0; r_done = 0; w_pushed = 0; w_done = 0;
   endtask

   task automatic push_ar(input bit f);
      ar_split_push = 1'b1; ar_split_flag = f;
      @(posedge aclk); #1;
      ar_split_push = 1'b0;
      r_pushed++;
   endtask

   task automatic push_aw(input bit f);
      aw_split_push = 1'b1; aw_split_flag = f;
      @(posedge aclk); #1;
      aw_split_push = 1'b0;
      w_pushed++;
   endtask

   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] d;
      for (int j = 0; j < DW / 32; j++) d[j*32 +: 32] = $urandom();
      return d;
   endfunction

   // One AXI R beat; expectation queued as the DMA side must see it
   task automatic send_r(input logic [DW-1:0] d, input logic [IDW-1:0] id, input logic [1:0] rs,
                         input bit in_last, input bit exp_last, input bit fin);
      int n;
      bit ok;
      rq.push_back('{data: d, id: id, resp: rs, last: exp_last});
      i_rvalid = 1'b1; i_rdata = d; i_rid = id; i_rresp = rs; i_rlast = in_last;
      n = 0; ok = 0;
      while (!ok && n < 2000) begin
         @(negedge aclk);
         ok = o_rready;
         n++;
      end
      if (!ok) begin
         checks++; failures++;
         $display("FAIL r_hs_timeout actual=no_ready required=ready at %0t", $time);
      end else if (fin) r_done++;
      @(posedge aclk); #1;
      i_rvalid = 1'b0; i_rlast = 1'b0;
   endtask

   // One logical read burst; DMA sees all beats contiguously with RLAST only on the final one
   task automatic rburst(input bit split, input int l1, input int l2, input logic [IDW-1:0] id);
      int total;
      bit il;
      total = l1 + (split ? l2 : 0);
      for (int k = 0; k < total; k++) begin
         il = split ? ((k == l1 - 1) || (k == total - 1)) : (k == total - 1);
         send_r(rnd_data(), id, 2'($urandom_range(0, 3)), il, (k == total - 1), (k == total - 1));
         if ($urandom_range(0, 3) == 0) begin @(posedge aclk); #1; end
      end
   endtask

   task automatic send_b(input logic [IDW-1:0] id, input logic [1:0] rs, input bit fin);
      int n;
      bit ok;
      i_bvalid = 1'b1; i_bid = id; i_bresp = rs;
      n = 0; ok = 0;
      while (!ok && n < 2000) begin
         @(negedge aclk);
         ok = o_bready;
         n++;
      end
      if (!ok) begin
         checks++; failures++;
         $display("FAIL b_hs_timeout actual=no_ready required=ready at %0t", $time);
      end else if (fin) w_done++;
      @(posedge aclk); #1;
      i_bvalid = 1'b0;
   endtask

   // One logical write burst: a split one yields a single response, the worse of the two
   task automatic bburst(input bit split, input logic [1:0] r1, input logic [1:0] r2, input logic [IDW-1:0] id);
      if (split) begin
         bq.push_back('{id: id, resp: worst(r1, r2)});
         send_b(id, r1, 1'b0);
         if ($urandom_range(0, 2) == 0) begin @(posedge aclk); #1; end
         send_b(id, r2, 1'b1);
      end else begin
         bq.push_back('{id: id, resp: r1});
         send_b(id, r1, 1'b1);
      end
   endtask

   initial begin
      ar_split_push = 1'b0; ar_split_flag = 1'b0;
      aw_split_push = 1'b0; aw_split_flag = 1'b0;
      i_rvalid = 1'b0; i_rlast = 1'b0; i_rid = '0; i_rdata = '0; i_rresp = '0;
      i_bvalid = 1'b0; i_bid = '0; i_bresp = '0;
      areset = 1'b1;
      @(posedge aclk); #1;
      do_reset();

      // Reset state; responses with empty flag FIFOs must stall
      i_rvalid = 1'b1; i_bvalid = 1'b1;
      @(negedge aclk);
      chk("rst_dma_rvalid", dma_rvalid, 1'b0);
      chk("rst_dma_bvalid", dma_bvalid, 1'b0);
      chk("rst_o_rready", o_rready, 1'b0);
      chk("rst_o_bready", o_bready, 1'b0);
      chk("rst_ar_full", ar_split_full, 1'b0);
      chk("rst_aw_full", aw_split_full, 1'b0);
      @(posedge aclk); #1;
      i_rvalid = 1'b0; i_bvalid = 1'b0;

      // Unsplit and split reads
      push_ar(1'b0); rburst(1'b0, 4, 0, 4'h3);
      push_ar(1'b1); rburst(1'b1, 3, 5, 4'h5);

      // Split and unsplit writes
      push_aw(1'b1); bburst(1'b1, 2'b00, 2'b10, 4'h1);
      push_aw(1'b1); bburst(1'b1, 2'b11, 2'b00, 4'h2);
      push_aw(1'b0); bburst(1'b0, 2'b01, 2'b00, 4'h7);
      push_aw(1'b1); bburst(1'b1, 2'b01, 2'b00, 4'h9);

      // Backpressure toggling on a split read
      rdy_mode = 1;
      push_ar(1'b1); rburst(1'b1, 3, 5, 4'hA);
      rdy_mode = 0;
      @(posedge aclk); #1;

      // Flag FIFO limits and wrap
      do_reset();
      push_ar(1'b0); push_ar(1'b1); push_ar(1'b0); push_ar(1'b1);
      @(negedge aclk);
      chk("full_lag", ar_split_full, 1'b0);
      @(posedge aclk); #1;
      @(negedge aclk);
      chk("full_set", ar_split_full, 1'b1);
      @(posedge aclk); #1;
      begin
         logic [DW-1:0] d;
         d = rnd_data();
         rq.push_back('{data: d, id: 4'h6, resp: 2'b00, last: 1'b1});
         i_rvalid = 1'b1; i_rdata = d; i_rid = 4'h6; i_rresp = 2'b00; i_rlast = 1'b1;
         ar_split_push = 1'b1; ar_split_flag = 1'b1;
         @(negedge aclk);
         chk("pushpop_ready", o_rready, 1'b1);
         @(posedge aclk); #1;
         i_rvalid = 1'b0; i_rlast = 1'b0; ar_split_push = 1'b0;
         r_pushed++; r_done++;
      end
      @(negedge aclk);
      chk("full_hold", ar_split_full, 1'b1);
      @(posedge aclk); #1;
      rburst(1'b1, 2, 1, 4'h1);
      rburst(1'b0, 2, 0, 4'h2);
      rburst(1'b1, 1, 1, 4'h3);
      rburst(1'b1, 3, 2, 4'h4);
      @(posedge aclk); #1;
      @(negedge aclk);
      chk("full_clear", ar_split_full, 1'b0);
      @(posedge aclk); #1;

      // Reset in the middle of a split read and a split write
      push_ar(1'b1); push_aw(1'b1);
      send_r(rnd_data(), 4'h8, 2'b00, 1'b0, 1'b0, 1'b0);
      send_r(rnd_data(), 4'h8, 2'b00, 1'b1, 1'b0, 1'b0);
      send_b(4'h8, 2'b11, 1'b0);
      areset = 1'b1;
      @(posedge aclk); #1;
      areset = 1'b0;
      r_pushed = 0; r_done = 0; w_pushed = 0; w_done = 0;
      i_rvalid = 1'b1; i_rlast = 1'b1; i_bvalid = 1'b1; i_bresp = 2'b00;
      @(negedge aclk);
      chk("mrst_dma_bvalid", dma_bvalid, 1'b0);
      chk("mrst_o_bready", o_bready, 1'b0);
      chk("mrst_dma_rvalid", dma_rvalid, 1'b0);
      chk("mrst_o_rready", o_rready, 1'b0);
      chk("mrst_aw_full", aw_split_full, 1'b0);
      @(posedge aclk); #1;
      i_rvalid = 1'b0; i_rlast = 1'b0; i_bvalid = 1'b0;
      push_aw(1'b0); bburst(1'b0, 2'b00, 2'b00, 4'hC);
      push_ar(1'b1); rburst(1'b1, 1, 1, 4'hD);

      // Randomized concurrent traffic on both directions
      for (int i = 0; i < NB; i++) begin
         rflag[i] = 1'($urandom_range(0, 1));
         rl1[i]   = $urandom_range(1, 6);
         rl2[i]   = $urandom_range(1, 6);
         wflag[i] = 1'($urandom_range(0, 1));
         wr1[i]   = 2'($urandom_range(0, 3));
         wr2[i]   = 2'($urandom_range(0, 3));
      end
      rdy_mode = 2;
      fork
         begin
            for (int i = 0; i < NB; i++) begin
               int n;
               n = 0;
               while (((r_pushed - r_done) >= DEPTH || ar_split_full) && n < 5000) begin
                  @(posedge aclk); #1; n++;
               end
               if (n >= 5000) begin
                  checks++; failures++;
                  $display("FAIL ar_push_timeout actual=blocked required=space");
               end
               push_ar(rflag[i]);
               if ($urandom_range(0, 2) == 0) begin @(posedge aclk); #1; end
            end
         end
         begin
            for (int i = 0; i < NB; i++) rburst(rflag[i], rl1[i], rl2[i], 4'($urandom_range(0, 15)));
         end
         begin
            for (int i = 0; i < NB; i++) begin
               int n;
               n = 0;
               while (((w_pushed - w_done) >= DEPTH || aw_split_full) && n < 5000) begin
                  @(posedge aclk); #1; n++;
               end
               if (n >= 5000) begin
                  checks++; failures++;
                  $display("FAIL aw_push_timeout actual=blocked required=space");
               end
               push_aw(wflag[i]);
               if ($urandom_range(0, 2) == 0) begin @(posedge aclk); #1; end
            end
         end
         begin
            for (int i = 0; i < NB; i++) bburst(wflag[i], wr1[i], wr2[i], 4'($urandom_range(0, 15)));
         end
      join

      repeat (4) @(posedge aclk);
      #1;
      chk("r_leftover", rq.size(), 0);
      chk("b_leftover", bq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axi_resp_merge4k.md
# axi_resp_merge4k

Response-side companion to the 4K-boundary address splitter in the iDMA AXI master path. When the address side splits one logical DMA burst into two AXI transactions, this block rejoins the returned R beats and B responses into one logical burst toward the DMA engine. It hides the intermediate RLAST and collapses the two write responses into a single worst-case BRESP. It sits between the AXI master port and the DMA read-data / write-response consumers.

## Interface
Parameters:
- AXI_IDW, 4, R/B ID width; IDs pass through unmodified.
- DATAW, 256, R data width.
- DEPTH, 4, outstanding logical bursts tracked per direction; power of two, ≥2.

Ports:
- aclk  in  1  clock
- areset  in  1  reset, synchronous, active-high
- ar_split_push  in  1  pulse: one logical read burst fully issued on AR
- ar_split_flag  in  1  that burst was split (two AR transactions)
- ar_split_full  out  1  read flag FIFO full; address side must stall
- aw_split_push / aw_split_flag / aw_split_full  in/in/out  1 each  same, write side
- i_rvalid, i_rlast  in  1 each; i_rid  in  AXI_IDW; i_rdata  in  DATAW; i_rresp  in  2
- o_rready  out  1
- dma_rvalid, dma_rlast  out  1 each; dma_rid  out  AXI_IDW; dma_rdata  out  DATAW; dma_rresp  out  2
- dma_rready  in  1
- i_bvalid  in  1; i_bid  in  AXI_IDW; i_bresp  in  2; o_bready  out  1
- dma_bvalid  out  1; dma_bid  out  AXI_IDW; dma_bresp  out  2; dma_bready  in  1

## Operation
- Two flag FIFOs, one for read and one for write. Each entry is one bit per logical burst, pushed in issue order; AXI returns in order (single ID).
- Read path, zero latency:
  - dma_rvalid = i_rvalid & !rfifo_empty.
  - o_rready = dma_rready & !rfifo_empty.
  - rdata, rid and rresp pass through per beat.
  - State r_seg2 (1 bit):
    - Head flag=1 and r_seg2=0: an accepted beat with i_rlast sets r_seg2. dma_rlast=0 on that beat. No pop.
    - r_seg2=1, or head flag=0: dma_rlast=i_rlast. An accepted last beat pops the head and clears r_seg2.
- Write path FSM with states B_IDLE and B_WAIT2:
  - B_IDLE, head flag=1:
    - dma_bvalid=0 and o_bready=1.
    - On i_bvalid, store bresp in b_hold and go to B_WAIT2.
  - B_IDLE, head flag=0:
    - Pass-through: dma_bvalid=i_bvalid, o_bready=dma_bready.
    - Pop on handshake.
  - B_WAIT2:
    - dma_bvalid=i_bvalid, o_bready=dma_bready, dma_bresp=max(b_hold, i_bresp), using the numeric order OKAY<EXOKAY<SLVERR<DECERR.
    - On handshake: pop and go to B_IDLE.
  - Flag FIFO empty: o_bready=0 and dma_bvalid=0, regardless of state.
- Flag FIFO rules:
  - Push while full without a simultaneous pop is dropped; the address side must honour full.
  - Push and pop in the same cycle are both accepted, including when full (count unchanged) and when empty with a pop request (no pop occurs; the push is taken).
  - Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- Responses arriving with the matching FIFO empty (protocol violation) are stalled, never dropped.

## Timing
- Reset values:
  - FIFOs empty, *_full=0.
  - r_seg2=0, FSM in B_IDLE, b_hold=0.
  - Hence dma_rvalid=0, dma_bvalid=0, o_rready=0, o_bready=0.
  - dma_rlast, dma_rresp and dma_bresp follow their inputs and carry no meaning while valid=0.
- Flag pushed in cycle t becomes the head at t+1. A beat or response arriving in t stalls one cycle.
- R path has no register stage: data latency 0, ready is combinational from dma_rready.
- B path:
  - Unsplit: latency 0.
  - Split: the first B is absorbed in 1 cycle, the merged B is presented combinationally with the second i_bvalid.
- *_full is registered: it asserts the cycle after count reaches DEPTH.
- Reset mid-burst: everything returns to reset state next cycle. In-flight AXI beats are not tracked after reset; the system resets the interconnect together with this block.

## Structure
- Shared package idma_pkg:
  - RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - function resp_worst(a,b).
  - enum b_state_t {B_IDLE, B_WAIT2}.
- Sub-module axi_split_flag_fifo, with parameters DEPTH and width 1, ports push/din/pop/dout/empty/full/count. Instantiated twice, once for read and once for write.

## Test plan
- Unsplit read: push flag 0, send 4 beats with rlast on beat 4 → 4 dma beats, dma_rlast on beat 4 only, one pop.
- Split read: push flag 1, send 3+5 beats with rlast on beats 3 and 8 → 8 contiguous dma beats, dma_rlast only on beat 8, r_seg2 high between.
- Split write: push flag 1, B1=OKAY then B2=SLVERR → exactly one dma_b with bresp=2'b10; reversed order (DECERR then OKAY) → 2'b11.
- Backpressure: dma_rready toggling 1/0 every cycle during a split read → no beat lost or duplicated, o_rready mirrors dma_rready.
- FIFO limits: push DEPTH flags with no responses → ar_split_full=1 one cycle later; push+pop in same cycle while full → count stays DEPTH, new flag stored at the correct wrap position.
- Reset mid-split: areset asserted in B_WAIT2 → next cycle FSM in B_IDLE, FIFOs empty, dma_bvalid=0, o_bready=0.
